// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, default timing and command codes.
// Imported by the host transmitter and reusable by the keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_BITS      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_tx_state_e;

    localparam int DEF_INHIBIT_CYC       = 6000;
    localparam int DEF_START_TIMEOUT_CYC = 750000;
    localparam int DEF_XFER_TIMEOUT_CYC  = 100000;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one open-collector PS/2 line plus falling-edge detect.
// Flops reset to 1, matching the idle (pulled-up) bus.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus one history stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-clock frame driven by
// the device clock, ACK check, and start/overall timeouts.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC       = DEF_INHIBIT_CYC,
    parameter int START_TIMEOUT_CYC = DEF_START_TIMEOUT_CYC,
    parameter int XFER_TIMEOUT_CYC  = DEF_XFER_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam logic [31:0] INHIBIT_LAST = 32'(INHIBIT_CYC - 1);
    localparam logic [31:0] START_LAST   = 32'(START_TIMEOUT_CYC - 1);
    localparam logic [31:0] XFER_LAST    = 32'(XFER_TIMEOUT_CYC - 1);

    ps2_tx_state_e state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          parity_q, parity_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   timer_q, timer_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ready_q, busy_q;
    logic          abort_s;
    logic          clk_sync_s, clk_fall_s;
    logic          dat_sync_s, dat_fall_unused;

    // Open-collector drivers: only ever pull low or release.
    assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;

    ps2_line_sync u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (PS2_CLK),
        .sync_o (clk_sync_s),
        .fall_o (clk_fall_s)
    );

    ps2_line_sync u_dat_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (PS2_DAT),
        .sync_o (dat_sync_s),
        .fall_o (dat_fall_unused)
    );

    // Next-state and next-output logic of the transmit FSM.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        parity_d = parity_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        abort_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    data_d   = tx_data;
                    parity_d = odd_parity(tx_data);
                    cnt_d    = 4'd0;
                    timer_d  = 32'd0;
                    clk_oe_d = 1'b1;
                    state_d  = ST_INHIBIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                if (timer_q == INHIBIT_LAST) begin
                    timer_d  = 32'd0;
                    dat_oe_d = 1'b1;
                    state_d  = ST_RTS;
                end else begin
                    timer_d  = timer_q + 32'd1;
                end
            end
            ST_RTS: begin
                clk_oe_d = 1'b0;
                timer_d  = 32'd0;
                state_d  = ST_BITS;
            end
            ST_BITS: begin
                // The timer measures the start timeout until fall 1, then the whole frame.
                if (clk_fall_s) begin
                    cnt_d   = cnt_q + 4'd1;
                    timer_d = (cnt_q == 4'd0) ? 32'd0 : timer_q + 32'd1;
                    if (cnt_q < 4'd8) begin
                        dat_oe_d = ~data_q[cnt_q[2:0]];
                    end else if (cnt_q == 4'd8) begin
                        dat_oe_d = ~parity_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = ST_ACK;
                    end
                end else if (timer_q == ((cnt_q == 4'd0) ? START_LAST : XFER_LAST)) begin
                    abort_s = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_ACK: begin
                if (clk_fall_s) begin
                    cnt_d = cnt_q + 4'd1;
                    if (!dat_sync_s) begin
                        timer_d = 32'd0;
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        abort_s = 1'b1;
                    end
                end else if (timer_q == XFER_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync_s && dat_sync_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q == XFER_LAST) begin
                    abort_s = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
        if (abort_s) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            err_d    = 1'b1;
            state_d  = ST_IDLE;
        end else begin
            err_d    = 1'b0;
        end
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_q   <= 8'd0;
            parity_q <= 1'b0;
            cnt_q    <= 4'd0;
            timer_q  <= 32'd0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= (state_d == ST_IDLE);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign tx_err   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// a scoreboard of expected frames is filled at each request and drained per frame.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH   = 6000;
    localparam int START = 2000;
    localparam int XFER  = 3000;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    wire        ps2_clk;
    wire        ps2_dat;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic [9:0] exp_q[$];

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYC       (INH),
        .START_TIMEOUT_CYC (START),
        .XFER_TIMEOUT_CYC  (XFER)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_err   (tx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_err === 1'b1) err_cnt++;
        if (tx_done === 1'b1 && tx_err === 1'b1) both_cnt++;
    end

    function automatic logic model_parity(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic send_req(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        exp_q.push_back({1'b1, model_parity(b), b});
    endtask

    // Device: wait for inhibit, measure it, then generate n_clk clocks sampling on rising edges.
    task automatic dev_xfer(input bit ack, input int n_clk, output logic [9:0] bits,
                            output logic start_bit, output int low_cyc, output bit ok);
        int t;
        ok = 1'b1; bits = '0; low_cyc = 0; t = 0;
        while (ps2_clk !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) ok = 1'b0;
        while (ps2_clk === 1'b0 && low_cyc < INH + 100) begin @(negedge clk); low_cyc++; end
        start_bit = ps2_dat;
        repeat (30) @(negedge clk);
        for (int i = 1; i <= n_clk; i++) begin
            if (i == 11 && ack) begin
                dev_dat_low = 1'b1;
                repeat (HALF) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i <= 10) bits[i-1] = ps2_dat;
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", tx_ready); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", tx_busy); end
        checks++; if (tx_done !== 1'b0 || tx_err !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b want=00", tx_done, tx_err); end
        checks++; if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1) begin failures++; $display("FAIL reset_lines got=%b%b want=11", ps2_clk, ps2_dat); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_set_led;
        logic [9:0] bits, exp; logic sb; int lc, d0, e0; bit ok;
        d0 = done_cnt; e0 = err_cnt;
        send_req(CMD_SET_LED);
        dev_xfer(1'b1, 11, bits, sb, lc, ok);
        repeat (20) @(negedge clk);
        checks++; if (!ok) begin failures++; $display("FAIL ed_inhibit_seen got=0 want=1"); end
        checks++; if (lc < INH || lc > INH + 1) begin failures++; $display("FAIL ed_inhibit_len got=%0d want=%0d..%0d", lc, INH, INH + 1); end
        checks++; if (sb !== 1'b0) begin failures++; $display("FAIL ed_start_bit got=%b want=0", sb); end
        exp = exp_q.pop_front();
        checks++; if (bits !== exp) begin failures++; $display("FAIL ed_frame got=%b want=%b", bits, exp); end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL ed_done_count got=%0d want=1", done_cnt - d0); end
        checks++; if (err_cnt - e0 != 0) begin failures++; $display("FAIL ed_err_count got=%0d want=0", err_cnt - e0); end
    endtask

    task automatic test_enable;
        logic [9:0] bits, exp; logic sb; int lc, n; bit ok;
        send_req(CMD_ENABLE);
        dev_xfer(1'b1, 11, bits, sb, lc, ok);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL f4_ready_early got=%b want=0", tx_ready); end
        n = 0;
        while (tx_done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++; if (tx_done !== 1'b1) begin failures++; $display("FAIL f4_done got=0 want=1 after %0d cycles", n); end
        checks++; if (tx_ready !== 1'b1 || ps2_clk !== 1'b1 || ps2_dat !== 1'b1) begin
            failures++; $display("FAIL f4_idle_lines got ready=%b clk=%b dat=%b want=111", tx_ready, ps2_clk, ps2_dat); end
        checks++; if (bits[8] !== 1'b0) begin failures++; $display("FAIL f4_parity got=%b want=0", bits[8]); end
        exp = exp_q.pop_front();
        checks++; if (bits !== exp) begin failures++; $display("FAIL f4_frame got=%b want=%b", bits, exp); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_nack;
        logic [9:0] bits, exp; logic sb; int lc, d0, e0; bit ok;
        d0 = done_cnt; e0 = err_cnt;
        send_req(8'h3C);
        dev_xfer(1'b0, 11, bits, sb, lc, ok);
        repeat (20) @(negedge clk);
        exp = exp_q.pop_front();
        checks++; if (bits !== exp) begin failures++; $display("FAIL nack_frame got=%b want=%b", bits, exp); end
        checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL nack_err_count got=%0d want=1", err_cnt - e0); end
        checks++; if (done_cnt - d0 != 0) begin failures++; $display("FAIL nack_done_count got=%0d want=0", done_cnt - d0); end
        checks++; if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin failures++; $display("FAIL nack_idle got ready=%b busy=%b want=10", tx_ready, tx_busy); end
    endtask

    task automatic test_start_timeout;
        int t, n, d0;
        logic [9:0] discard;
        d0 = done_cnt;
        send_req(8'h12);
        discard = exp_q.pop_front();
        t = 0;
        while (ps2_clk !== 1'b1 && t < INH + 100) begin @(negedge clk); t++; end
        checks++; if (ps2_dat !== 1'b0) begin failures++; $display("FAIL to_start_bit got=%b want=0", ps2_dat); end
        n = 0;
        while (tx_err !== 1'b1 && n < START + 50) begin @(negedge clk); n++; end
        checks++; if (n < START - 3 || n > START + 3) begin failures++; $display("FAIL to_latency got=%0d want=%0d+-3 (last=%b)", n, START, discard[9]); end
        checks++; if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1) begin failures++; $display("FAIL to_lines got=%b%b want=11", ps2_clk, ps2_dat); end
        repeat (5) @(negedge clk);
        checks++; if (done_cnt != d0 || tx_ready !== 1'b1) begin failures++; $display("FAIL to_idle got done=%0d ready=%b want=%0d,1", done_cnt - d0, tx_ready, 0); end
    endtask

    task automatic test_reset_mid;
        logic [9:0] bits, exp; logic sb; int lc, d0, e0; bit ok;
        d0 = done_cnt; e0 = err_cnt;
        send_req(8'h00);
        dev_xfer(1'b1, 5, bits, sb, lc, ok);
        checks++; if (ps2_dat !== 1'b0) begin failures++; $display("FAIL rst_dat_driven got=%b want=0", ps2_dat); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1) begin failures++; $display("FAIL rst_lines got=%b%b want=11", ps2_clk, ps2_dat); end
        @(negedge clk);
        rst = 1'b0;
        checks++; if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin failures++; $display("FAIL rst_state got ready=%b busy=%b want=10", tx_ready, tx_busy); end
        repeat (10) @(negedge clk);
        checks++; if (done_cnt != d0 || err_cnt != e0) begin failures++; $display("FAIL rst_pulses got done=%0d err=%0d want=0,0", done_cnt - d0, err_cnt - e0); end
        exp_q.delete();
        d0 = done_cnt;
        send_req(CMD_RESET);
        dev_xfer(1'b1, 11, bits, sb, lc, ok);
        repeat (20) @(negedge clk);
        exp = exp_q.pop_front();
        checks++; if (bits !== exp) begin failures++; $display("FAIL ff_frame got=%b want=%b", bits, exp); end
        checks++; if (bits[8] !== 1'b1) begin failures++; $display("FAIL ff_parity got=%b want=1", bits[8]); end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL ff_done_count got=%0d want=1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] bits, exp; logic sb; int lc, d0; bit ok;
        logic busy_seen, ready_seen;
        d0 = done_cnt;
        send_req(8'hA3);
        busy_seen = 1'b1; ready_seen = 1'b0;
        fork
            dev_xfer(1'b1, 11, bits, sb, lc, ok);
            begin
                for (int k = 0; k < 2; k++) begin
                    repeat ((k == 0) ? 200 : 5950) @(negedge clk);
                    busy_seen  = busy_seen & tx_busy;
                    ready_seen = ready_seen | tx_ready;
                    tx_data  = 8'h55;
                    tx_valid = 1'b1;
                    @(negedge clk);
                    tx_valid = 1'b0;
                end
            end
        join
        repeat (20) @(negedge clk);
        checks++; if (busy_seen !== 1'b1 || ready_seen !== 1'b0) begin failures++; $display("FAIL b2b_busy got busy=%b ready=%b want=10", busy_seen, ready_seen); end
        exp = exp_q.pop_front();
        checks++; if (bits !== exp) begin failures++; $display("FAIL b2b_frame got=%b want=%b", bits, exp); end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL b2b_done_count got=%0d want=1", done_cnt - d0); end
        checks++; if (ps2_clk !== 1'b1 || tx_ready !== 1'b1) begin failures++; $display("FAIL b2b_no_retx got clk=%b ready=%b want=11", ps2_clk, tx_ready); end
    endtask

    task automatic test_exclusive;
        checks++; if (both_cnt != 0) begin failures++; $display("FAIL done_err_overlap got=%0d want=0", both_cnt); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_set_led();
        test_enable();
        test_nack();
        test_start_timeout();
        test_reset_mid();
        test_back_to_back();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
